// File: rtl/jk_pkg.sv
// Shared definitions for JK flip-flop checking: command codes, monitor FSM
// states and the reference next-state function.
package jk_pkg;

  // {j,k} command codes
  localparam logic [1:0] JK_HOLD = 2'b00;
  localparam logic [1:0] JK_RST  = 2'b01;
  localparam logic [1:0] JK_SET  = 2'b10;
  localparam logic [1:0] JK_TOG  = 2'b11;

  typedef enum logic [1:0] {
    UNSYNC = 2'd0,
    TRACK  = 2'd1,
    HALT   = 2'd2
  } mon_state_t;

  // Value a JK flip-flop takes at the next edge, given its current q.
  function automatic logic jk_next(input logic q, input logic j, input logic k);
    logic r;
    r = q;
    case ({j, k})
      JK_HOLD: r = q;
      JK_RST:  r = 1'b0;
      JK_SET:  r = 1'b1;
      JK_TOG:  r = ~q;
      default: r = q;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/jk_ff_monitor_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] CNT_MAX = {W{1'b1}};

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: clear first, otherwise step unless already at the ceiling.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/jk_ff_monitor.sv
// Clocked checker for a JK flip-flop: syncs to a known q via SET/RESET,
// then predicts q every enabled edge and flags, counts and latches mismatches.
module jk_ff_monitor
  import jk_pkg::*;
#(
  parameter int CNT_W       = 8,
  parameter bit STOP_ON_ERR = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             j,
  input  logic             k,
  input  logic             q,
  output logic             synced,
  output logic             exp_q,
  output logic             mismatch,
  output logic             err_sticky,
  output logic             halted,
  output logic [CNT_W-1:0] toggle_cnt,
  output logic [CNT_W-1:0] mism_cnt
);

  mon_state_t state_q, state_d;
  logic       exp_q_q, exp_q_d;
  logic       chk_pend_q, chk_pend_d;
  logic       q_prev_q, q_prev_d;
  logic       mismatch_q, mismatch_d;
  logic       err_q, err_d;
  logic       tog_inc;
  logic       mism_inc;
  logic [1:0] jk_cmd;
  logic       miss;

  assign jk_cmd = {j, k};
  // Only a pending check may compare; the first edge after sync or after
  // an en=0 gap merely re-predicts.
  assign miss   = chk_pend_q && (q != exp_q_q);

  // Next-state and per-edge bookkeeping; all outputs come from registers.
  always_comb begin
    state_d    = state_q;
    exp_q_d    = exp_q_q;
    chk_pend_d = chk_pend_q;
    q_prev_d   = q_prev_q;
    mismatch_d = 1'b0;
    err_d      = err_q;
    tog_inc    = 1'b0;
    mism_inc   = 1'b0;

    if (!en) begin
      chk_pend_d = 1'b0;
    end else begin
      case (state_q)
        UNSYNC: begin
          // The flop has no reset, so only SET or RESET give a known q.
          if (jk_cmd == JK_SET || jk_cmd == JK_RST) begin
            exp_q_d    = j;
            q_prev_d   = j;
            chk_pend_d = 1'b1;
            state_d    = TRACK;
          end
        end
        TRACK: begin
          if (miss) begin
            mismatch_d = 1'b1;
            mism_inc   = 1'b1;
            err_d      = 1'b1;
            if (STOP_ON_ERR) begin
              state_d = HALT;
            end
          end
          tog_inc    = (q != q_prev_q);
          q_prev_d   = q;
          // Re-base on the observed q so a single fault yields one mismatch.
          exp_q_d    = jk_next(q, j, k);
          chk_pend_d = 1'b1;
        end
        HALT: begin
          // Frozen until reset.
        end
        default: begin
          state_d = UNSYNC;
        end
      endcase
    end

    if (clr) begin
      err_d = 1'b0;
    end
  end

  // State and flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= UNSYNC;
      exp_q_q    <= 1'b0;
      chk_pend_q <= 1'b0;
      q_prev_q   <= 1'b0;
      mismatch_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      exp_q_q    <= exp_q_d;
      chk_pend_q <= chk_pend_d;
      q_prev_q   <= q_prev_d;
      mismatch_q <= mismatch_d;
      err_q      <= err_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_toggle_cnt (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .inc (tog_inc),
    .cnt (toggle_cnt)
  );

  sat_counter #(.W(CNT_W)) u_mism_cnt (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .inc (mism_inc),
    .cnt (mism_cnt)
  );

  assign synced     = (state_q != UNSYNC);
  assign halted     = (state_q == HALT);
  assign exp_q      = exp_q_q;
  assign mismatch   = mismatch_q;
  assign err_sticky = err_q;

endmodule

// File: tb/tb_jk_ff_monitor.sv
// Bench for jk_ff_monitor: three instances (default, stop-on-error, 2-bit
// counters) share one stimulus stream and a behavioural JK flop whose q can
// be overridden to inject faults.
module tb_jk_ff_monitor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1, en = 1'b0, clr = 1'b0, j = 1'b0, k = 1'b0;
  logic ff_q = 1'b0, force_en = 1'b0, force_val = 1'b0;
  logic q;
  assign q = force_en ? force_val : ff_q;

  // The flip-flop under observation.
  always @(posedge clk) begin
    if (j && k)      ff_q <= ~ff_q;
    else if (j)      ff_q <= 1'b1;
    else if (k)      ff_q <= 1'b0;
  end

  logic [2:0] syn_w, exp_w, mm_w, err_w, hlt_w;
  logic [7:0] tcnt0, mcnt0, tcnt1, mcnt1;
  logic [1:0] tcnt2, mcnt2;

  jk_ff_monitor #(.CNT_W(8), .STOP_ON_ERR(1'b0)) dut0 (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .j(j), .k(k), .q(q),
    .synced(syn_w[0]), .exp_q(exp_w[0]), .mismatch(mm_w[0]), .err_sticky(err_w[0]),
    .halted(hlt_w[0]), .toggle_cnt(tcnt0), .mism_cnt(mcnt0));

  jk_ff_monitor #(.CNT_W(8), .STOP_ON_ERR(1'b1)) dut1 (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .j(j), .k(k), .q(q),
    .synced(syn_w[1]), .exp_q(exp_w[1]), .mismatch(mm_w[1]), .err_sticky(err_w[1]),
    .halted(hlt_w[1]), .toggle_cnt(tcnt1), .mism_cnt(mcnt1));

  jk_ff_monitor #(.CNT_W(2), .STOP_ON_ERR(1'b0)) dut2 (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .j(j), .k(k), .q(q),
    .synced(syn_w[2]), .exp_q(exp_w[2]), .mismatch(mm_w[2]), .err_sticky(err_w[2]),
    .halted(hlt_w[2]), .toggle_cnt(tcnt2), .mism_cnt(mcnt2));

  // ---------------- behavioural model ----------------
  // phase: 0 = not yet synced, 1 = tracking, 2 = stopped
  typedef struct {
    int phase;
    bit pred;
    bit armed;
    bit last_q;
    bit pulse;
    bit sticky;
    int toggles;
    int faults;
  } model_t;

  model_t m[3];
  int     stop_p[3] = '{0, 1, 0};
  int     max_p[3]  = '{255, 255, 3};
  // JK truth table indexed by {j,k} then present q.
  bit     jk_tbl[4][2] = '{'{1'b0, 1'b1}, '{1'b0, 1'b0}, '{1'b1, 1'b1}, '{1'b1, 1'b0}};

  function automatic model_t model_edge(input model_t s, input bit r, input bit e,
                                        input bit c, input bit jj, input bit kk,
                                        input bit qq, input int stop, input int maxc);
    model_t n;
    int     cmd;
    n   = s;
    cmd = {30'd0, jj, kk};
    if (r) begin
      n = '{0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0};
      return n;
    end
    n.pulse = 1'b0;
    if (!e) begin
      n.armed = 1'b0;
    end else if (s.phase == 0) begin
      if (cmd == 1 || cmd == 2) begin
        n.phase  = 1;
        n.pred   = jj;
        n.last_q = jj;
        n.armed  = 1'b1;
      end
    end else if (s.phase == 1) begin
      if (s.armed && qq != s.pred) begin
        n.pulse  = 1'b1;
        n.sticky = 1'b1;
        n.faults = (s.faults < maxc) ? s.faults + 1 : maxc;
        if (stop != 0) n.phase = 2;
      end
      if (qq != s.last_q) n.toggles = (s.toggles < maxc) ? s.toggles + 1 : maxc;
      n.last_q = qq;
      n.pred   = jk_tbl[cmd][qq];
      n.armed  = 1'b1;
    end
    if (c) begin
      n.toggles = 0;
      n.faults  = 0;
      n.sticky  = 1'b0;
    end
    return n;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      m[i] <= model_edge(m[i], rst, en, clr, j, k, q, stop_p[i], max_p[i]);
    end
  end

  // ---------------- checking ----------------
  int tests = 0;
  int fails = 0;
  bit checking = 1'b0;
  int cyc = 0;

  always @(negedge clk) begin
    cyc++;
    if (checking) begin
      for (int i = 0; i < 3; i++) begin
        logic [4:0] act_f, exp_f;
        int act_t, act_m;
        case (i)
          0:       begin act_t = int'(tcnt0); act_m = int'(mcnt0); end
          1:       begin act_t = int'(tcnt1); act_m = int'(mcnt1); end
          default: begin act_t = int'(tcnt2); act_m = int'(mcnt2); end
        endcase
        act_f = {syn_w[i], exp_w[i], mm_w[i], err_w[i], hlt_w[i]};
        exp_f = {(m[i].phase != 0), m[i].pred, m[i].pulse, m[i].sticky, (m[i].phase == 2)};
        tests++;
        if (act_f !== exp_f || act_t != m[i].toggles || act_m != m[i].faults) begin
          fails++;
          $display("FAIL model_cmp cyc=%0d dut%0d: got syn/exp/mm/err/hlt=%b tcnt=%0d mcnt=%0d, need %b tcnt=%0d mcnt=%0d",
                   cyc, i, act_f, act_t, act_m, exp_f, m[i].toggles, m[i].faults);
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int want);
    tests++;
    if (act != want) begin
      fails++;
      $display("FAIL %s: got %0d, need %0d", name, act, want);
    end
  endtask

  // Apply inputs at a negedge, let one rising edge pass, return at the next negedge.
  task automatic step(input logic e, input logic c, input logic jj, input logic kk);
    en = e; clr = c; j = jj; k = kk;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; clr = 1'b0; force_en = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    checking = 1'b1;
    check("reset_synced", int'(syn_w[0]), 0);
    check("reset_tcnt", int'(tcnt0), 0);

    // 1: HOLD and TOGGLE never sync
    do_reset();
    repeat (3) step(1, 0, 0, 0);
    repeat (2) step(1, 0, 1, 1);
    check("t1_synced", int'(syn_w[0]), 0);
    check("t1_tcnt", int'(tcnt0), 0);
    check("t1_mcnt", int'(mcnt0), 0);

    // 2: SET, RESET, TOGGLE, TOGGLE, HOLD against the real flop
    do_reset();
    step(1, 0, 1, 0);
    check("t2_synced", int'(syn_w[0]), 1);
    step(1, 0, 0, 1);
    step(1, 0, 1, 1);
    step(1, 0, 1, 1);
    step(1, 0, 0, 0);
    check("t2_tcnt", int'(tcnt0), 3);
    check("t2_mcnt", int'(mcnt0), 0);
    check("t2_err", int'(err_w[0]), 0);

    // 3/4: q stuck at 0 after SET sync
    do_reset();
    step(1, 0, 1, 0);
    force_en = 1'b1; force_val = 1'b0;
    step(1, 0, 0, 0);
    check("t3_pulse", int'(mm_w[0]), 1);
    check("t3_mcnt", int'(mcnt0), 1);
    check("t4_halted", int'(hlt_w[1]), 1);
    step(1, 0, 0, 0);
    check("t3_pulse_end", int'(mm_w[0]), 0);
    check("t3_rebase", int'(exp_w[0]), 0);
    check("t3_mcnt_hold", int'(mcnt0), 1);
    check("t3_err", int'(err_w[0]), 1);
    force_val = 1'b1;
    step(1, 0, 1, 1);
    step(1, 0, 1, 1);
    check("t4_tcnt_frozen", int'(tcnt1), 1);
    check("t4_mcnt_frozen", int'(mcnt1), 1);
    check("t4_still_halted", int'(hlt_w[1]), 1);
    do_reset();
    check("t4_rst_outs", int'({syn_w[1], exp_w[1], mm_w[1], err_w[1], hlt_w[1]}), 0);
    check("t4_rst_cnts", int'(tcnt1) + int'(mcnt1), 0);

    // 5: saturation with 2-bit counters, then clear with a toggle
    step(1, 0, 1, 0);
    repeat (6) step(1, 0, 1, 1);
    check("t5_sat", int'(tcnt2), 3);
    check("t5_wide", int'(tcnt0), 5);
    step(1, 1, 1, 1);
    check("t5_clr_sat", int'(tcnt2), 0);
    check("t5_clr_wide", int'(tcnt0), 0);

    // 6: en=0 gap while q is wrong, then re-enable
    do_reset();
    step(1, 0, 1, 0);
    step(1, 0, 0, 0);
    force_en = 1'b1; force_val = 1'b0;
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    check("t6_gap_pulse", int'(mm_w[0]), 0);
    check("t6_gap_exp", int'(exp_w[0]), 1);
    step(1, 0, 0, 0);
    check("t6_first_en", int'(mm_w[0]), 0);
    check("t6_first_mcnt", int'(mcnt0), 0);
    force_en = 1'b0;
    step(1, 0, 0, 0);
    check("t6_second_en", int'(mm_w[0]), 1);
    check("t6_second_mcnt", int'(mcnt0), 1);
    force_en = 1'b1; force_val = 1'b0;
    step(1, 1, 0, 0);
    check("clr_mm_pulse", int'(mm_w[0]), 1);
    check("clr_mm_cnt", int'(mcnt0), 0);
    check("clr_mm_err", int'(err_w[0]), 0);

    force_en = 1'b0;
    step(0, 0, 0, 0);
    checking = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
